bp_fetch_lookup: RTL and testbench
==================================

// Module: bp_fetch_lookup
// PURPOSE
// - Fetch-side reader of the 2-bit saturating branch predictor table; pairs with the execute-side resolution path.
// - Accepts a PC lookup from fetch and returns a registered taken/not-taken prediction.
// - Holds each issued prediction in an in-order in-flight queue until execute resolves it.
// - Flags mispredicts and applies the counter update to the table.
// PARAMETERS
// - IDX_W  10  table index width; 2**IDX_W entries, index = pc[IDX_W+1:2]
// - DEPTH  4   in-flight queue entries (power of two, >=2)
// PORTS
// - CLK           in   1   clock, rising edge
// - RESET         in   1   asynchronous, active-low reset
// - req_valid     in   1   fetch lookup request
// - req_pc        in   32  PC of the looked-up branch
// - req_ready     out  1   lookup accepted; = !queue_full
// - resp_valid    out  1   prediction valid, one cycle after accept
// - resp_taken    out  1   prediction (counter MSB)
// - res_valid     in   1   execute resolves the oldest in-flight branch
// - res_taken     in   1   actual direction
// - mispredict    out  1   registered pulse: res_taken != stored prediction
// - flush         in   1   discard all in-flight entries (pipeline redirect)
// - inflight_cnt  out  $clog2(DEPTH)+1  current queue occupancy
// BEHAVIOUR
// - Reset: every counter = WNT (2'b01); queue empty; resp_valid, resp_taken, mispredict = 0; inflight_cnt = 0.
// - Accept: req_valid && req_ready.
//   - Next cycle: resp_valid=1 and resp_taken=ctr[idx][1].
//   - The entry {idx, ctr, pred} is pushed at the accept edge.
// - Latency: lookup 1 cycle; resolution-to-mispredict 1 cycle; table write on the resolve edge.
// - Resolve with res_valid and queue non-empty:
//   - Pop the head.
//   - Write ctr[idx] = sat_next(stored ctr, res_taken): ST/SNT saturate, otherwise +/-1.
//   - mispredict = (res_taken != pred) on the next cycle.
// - res_valid with the queue empty is ignored: no write, no pulse.
// - Bypass: a lookup whose index equals the index being written that edge returns the new counter value.
// - Simultaneous push and pop when full: req_ready = 0, so no push that cycle; the pop proceeds.
// - Simultaneous push and pop otherwise: both happen; occupancy is unchanged.
// - Flush:
//   - The queue empties at the edge.
//   - A same-cycle resolve still updates the table and may pulse mispredict.
//   - A same-cycle accept is dropped; resp_valid=0 next cycle.
// - Pointers wrap mod DEPTH; occupancy is tracked separately from the pointers.
// - Async reset mid-operation clears the table and queue immediately; outputs drop the same cycle.
// - Table storage: plain register array (no RAM macro), fully reset.
// CONFIGURATION
// - BP_STATS_EN defined adds outputs stat_lookups[31:0] and stat_mispred[31:0].
//   - stat_lookups counts accepted lookups; stat_mispred counts mispredict pulses.
//   - Both saturate at 32'hFFFFFFFF and reset to 0.
// - BP_STATS_EN undefined: neither port nor counter exists; all other behaviour is identical.
// STRUCTURE
// - Package bp_pkg holds:
//   - Counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
//   - Function sat_next(ctr, taken).
//   - Typedef bp_entry_t {idx, ctr, pred}.
// - Sub-module bp_inflight_fifo: DEPTH-entry synchronous FIFO of bp_entry_t with push, pop, flush, full, empty, count.
// - The top level contains the table, bypass and response registers.
// TESTING
// - Reset, then lookup pc=0x100 -> resp_valid=1 after 1 cycle; resp_taken=0 (WNT).
// - Resolve pc 0x100 taken twice (lookup, resolve, repeat):
//   - First resolve -> mispredict=1 (WNT->WT).
//   - Next lookup -> resp_taken=1; second resolve -> mispredict=0 (ST).
// - Issue 4 lookups without resolve -> req_ready=0 and inflight_cnt=4; one resolve -> req_ready=1 the next cycle.
// - Resolve idx 5 to WT while a same-cycle lookup hits idx 5 -> resp_taken reflects the new value (bypass).
// - Flush with 3 in flight plus a same-cycle resolve -> head counter updated, inflight_cnt=0, later res_valid ignored.
// - With BP_STATS_EN: 10 lookups and 3 mispredicts -> stat_lookups=10, stat_mispred=3; RESET low -> both 0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor fetch path.
// Holds the 2-bit counter encodings, the in-flight entry layout and the
// saturating counter update used when execute resolves a branch.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // The in-flight entry carries the widest index any configuration can use
  // (pc[31:2]); narrower tables zero-extend and the spare bits fold away.
  localparam int BP_IDX_MAX_W = 30;

  typedef struct packed {
    logic [BP_IDX_MAX_W-1:0] idx;
    logic [1:0]              ctr;
    logic                    pred;
  } bp_entry_t;

  function automatic logic [1:0] sat_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-order queue of issued predictions awaiting resolution.
// Occupancy is kept in its own counter so the pointers can simply wrap.
// Flush empties the queue and wins over a same-cycle push.
module bp_inflight_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     push,
  input  bp_entry_t                push_entry,
  input  logic                     pop,
  input  logic                     flush,
  output bp_entry_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  bp_entry_t       mem [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  // Pointer and occupancy bookkeeping; flush returns everything to empty.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wptr] <= push_entry;
  end

endmodule

// File: rtl/bp_fetch_lookup.sv
// Fetch-side reader of the 2-bit saturating branch predictor table.
// Looks up a PC, returns a registered prediction one cycle later, queues the
// prediction until execute resolves it, then updates the counter and flags
// mispredicts. A lookup that hits the entry being written gets the new value.
// Optional: define BP_STATS_EN to add the stat_lookups / stat_mispred counters.
module bp_fetch_lookup
  import bp_pkg::*;
#(
  parameter int IDX_W = 10,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     req_valid,
  input  logic [31:0]              req_pc,
  output logic                     req_ready,
  output logic                     resp_valid,
  output logic                     resp_taken,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     mispredict,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   inflight_cnt
`ifdef BP_STATS_EN
  ,
  output logic [31:0]              stat_lookups,
  output logic [31:0]              stat_mispred
`endif
);

  localparam int ENTRIES = 2 ** IDX_W;

  logic [1:0]        bp_table [ENTRIES];
  logic [IDX_W-1:0]  lk_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic [1:0]        lk_ctr;
  logic [1:0]        wr_ctr;
  logic              accept;
  logic              push;
  logic              resolve;
  logic              mis_next;
  logic              fifo_full;
  logic              fifo_empty;
  bp_entry_t         head;
  bp_entry_t         push_entry;
  logic              unused_bits;

  assign lk_idx      = req_pc[IDX_W+1:2];
  assign req_ready   = !fifo_full;
  assign unused_bits = ^{req_pc[31:IDX_W+2], req_pc[1:0], head.idx[BP_IDX_MAX_W-1:IDX_W]};

  // Accept/resolve decode, counter update and write-to-read bypass.
  always_comb begin
    accept     = req_valid && req_ready;
    push       = accept && !flush;
    resolve    = res_valid && !fifo_empty;
    wr_idx     = head.idx[IDX_W-1:0];
    wr_ctr     = sat_next(head.ctr, res_taken);
    mis_next   = resolve && (res_taken != head.pred);
    lk_ctr     = bp_table[lk_idx];
    if (resolve && (wr_idx == lk_idx)) lk_ctr = wr_ctr;
    push_entry      = '0;
    push_entry.idx  = BP_IDX_MAX_W'(lk_idx);
    push_entry.ctr  = lk_ctr;
    push_entry.pred = lk_ctr[1];
  end

  bp_inflight_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK        (CLK),
    .RESET      (RESET),
    .push       (push),
    .push_entry (push_entry),
    .pop        (resolve),
    .flush      (flush),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (inflight_cnt)
  );

  // Counter table: all entries start weakly-not-taken; resolve writes the head's index.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < ENTRIES; i++) bp_table[i] <= WNT;
    end else if (resolve) begin
      bp_table[wr_idx] <= wr_ctr;
    end
  end

  // Registered response and mispredict pulse; a flushed accept gives no response.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      resp_valid <= 1'b0;
      resp_taken <= 1'b0;
      mispredict <= 1'b0;
    end else begin
      resp_valid <= push;
      resp_taken <= push ? lk_ctr[1] : 1'b0;
      mispredict <= mis_next;
    end
  end

`ifdef BP_STATS_EN
  // Saturating event counters for accepted lookups and mispredict pulses.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      stat_lookups <= '0;
      stat_mispred <= '0;
    end else begin
      if (accept && (stat_lookups != 32'hFFFF_FFFF))   stat_lookups <= stat_lookups + 32'd1;
      if (mis_next && (stat_mispred != 32'hFFFF_FFFF)) stat_mispred <= stat_mispred + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_fetch_lookup.sv
// Self-checking bench for bp_fetch_lookup: directed scenarios followed by
// randomized traffic, all compared against a sequential reference model of
// the predictor table and in-flight queue.
module tb_bp_fetch_lookup;

  localparam int IDX_W = 10;
  localparam int DEPTH = 4;
  localparam int NENT  = 1 << IDX_W;

  logic        CLK;
  logic        RESET;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_taken;
  logic        res_valid;
  logic        res_taken;
  logic        mispredict;
  logic        flush;
  logic [2:0]  inflight_cnt;
`ifdef BP_STATS_EN
  logic [31:0] stat_lookups;
  logic [31:0] stat_mispred;
`endif

  bp_fetch_lookup #(
    .IDX_W (IDX_W),
    .DEPTH (DEPTH)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .req_valid    (req_valid),
    .req_pc       (req_pc),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_taken   (resp_taken),
    .res_valid    (res_valid),
    .res_taken    (res_taken),
    .mispredict   (mispredict),
    .flush        (flush),
    .inflight_cnt (inflight_cnt)
`ifdef BP_STATS_EN
    ,
    .stat_lookups (stat_lookups),
    .stat_mispred (stat_mispred)
`endif
  );

  // Clock generation.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int idx;
    int ctr;
    bit pred;
  } mentry_t;

  int      mctr [NENT];
  mentry_t mq [$];
  int      m_lookups;
  int      m_mispred;
  int      vectors;
  int      miscompares;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NENT; i++) mctr[i] = 1;
    mq.delete();
    m_lookups = 0;
    m_mispred = 0;
  endtask

  // Drive one cycle of inputs, advance the model, and check the registered outputs.
  task automatic applyStimulus(input bit v, input logic [31:0] pc, input bit rv, input bit rt, input bit fl);
    bit      acc;
    bit      exp_mis;
    int      lidx;
    int      c;
    mentry_t h;
    mentry_t e;
    req_valid = v;
    req_pc    = pc;
    res_valid = rv;
    res_taken = rt;
    flush     = fl;
    #1;
    checkOutput("req_ready", req_ready, (mq.size() < DEPTH) ? 1 : 0);
    checkOutput("inflight_cnt_pre", inflight_cnt, mq.size());
    acc     = v && (mq.size() < DEPTH);
    exp_mis = 0;
    if (rv && mq.size() > 0) begin
      h = mq.pop_front();
      if (rt) mctr[h.idx] = (h.ctr == 3) ? 3 : h.ctr + 1;
      else    mctr[h.idx] = (h.ctr == 0) ? 0 : h.ctr - 1;
      exp_mis = (rt != h.pred);
    end
    lidx = (pc >> 2) % NENT;
    c    = mctr[lidx];
    if (acc) m_lookups++;
    if (exp_mis) m_mispred++;
    if (acc && !fl) begin
      e.idx  = lidx;
      e.ctr  = c;
      e.pred = (c >= 2);
      mq.push_back(e);
    end
    if (fl) mq.delete();
    @(posedge CLK);
    #1;
    checkOutput("resp_valid", resp_valid, (acc && !fl) ? 1 : 0);
    if (acc && !fl) checkOutput("resp_taken", resp_taken, (c >= 2) ? 1 : 0);
    checkOutput("mispredict", mispredict, exp_mis ? 1 : 0);
    checkOutput("inflight_cnt", inflight_cnt, mq.size());
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_resp_valid"}, resp_valid, 0);
    checkOutput({tag, "_resp_taken"}, resp_taken, 0);
    checkOutput({tag, "_mispredict"}, mispredict, 0);
    checkOutput({tag, "_inflight"}, inflight_cnt, 0);
    checkOutput({tag, "_req_ready"}, req_ready, 1);
`ifdef BP_STATS_EN
    checkOutput({tag, "_stat_lookups"}, stat_lookups, 0);
    checkOutput({tag, "_stat_mispred"}, stat_mispred, 0);
`endif
  endtask

  task automatic checkStats(input string tag);
`ifdef BP_STATS_EN
    checkOutput({tag, "_stat_lookups"}, stat_lookups, m_lookups);
    checkOutput({tag, "_stat_mispred"}, stat_mispred, m_mispred);
`else
    vectors = vectors + 0;
`endif
  endtask

  initial begin
    logic [31:0] pc;
    vectors     = 0;
    miscompares = 0;
    req_valid   = 0;
    req_pc      = '0;
    res_valid   = 0;
    res_taken   = 0;
    flush       = 0;
    RESET       = 1'b0;
    modelReset();
    #1;
    checkResetState("reset");
    repeat (3) @(negedge CLK);
    RESET = 1'b1;

    // Lookup of a fresh entry predicts not-taken.
    applyStimulus(1, 32'h100, 0, 0, 0);
    checkOutput("t1_resp_valid", resp_valid, 1);
    checkOutput("t1_resp_taken", resp_taken, 0);
    // First taken resolve mispredicts and moves WNT to WT.
    applyStimulus(0, 32'h0, 1, 1, 0);
    checkOutput("t1_mis1", mispredict, 1);
    applyStimulus(1, 32'h100, 0, 0, 0);
    checkOutput("t1_taken2", resp_taken, 1);
    applyStimulus(0, 32'h0, 1, 1, 0);
    checkOutput("t1_mis2", mispredict, 0);

    // Fill the queue, then free one slot.
    for (int i = 0; i < 4; i++) applyStimulus(1, 32'h200 + 32'(i * 4), 0, 0, 0);
    checkOutput("full_req_ready", req_ready, 0);
    checkOutput("full_inflight", inflight_cnt, 4);
    applyStimulus(1, 32'h210, 1, 0, 0);
    checkOutput("full_resp_valid", resp_valid, 0);
    checkOutput("after_pop_req_ready", req_ready, 1);
    applyStimulus(0, 32'h0, 0, 0, 1);

    // Bypass: resolve idx 5 to WT while looking up idx 5.
    applyStimulus(1, 32'h14, 0, 0, 0);
    applyStimulus(1, 32'h14, 1, 1, 0);
    checkOutput("bypass_taken", resp_taken, 1);
    checkOutput("bypass_mis", mispredict, 1);

    // Flush with 3 in flight, same-cycle resolve and dropped request.
    applyStimulus(1, 32'h30, 0, 0, 0);
    applyStimulus(1, 32'h34, 0, 0, 0);
    checkOutput("flush_pre_inflight", inflight_cnt, 3);
    applyStimulus(1, 32'h38, 1, 0, 1);
    checkOutput("flush_inflight", inflight_cnt, 0);
    checkOutput("flush_resp_valid", resp_valid, 0);
    checkOutput("flush_mis", mispredict, 1);
    applyStimulus(0, 32'h0, 1, 1, 0);
    checkOutput("empty_res_mis", mispredict, 0);
    applyStimulus(1, 32'h14, 0, 0, 0);
    checkOutput("flush_head_updated", resp_taken, 0);
    applyStimulus(0, 32'h0, 1, 0, 0);
    checkStats("directed");

    // Randomized traffic over a small set of aliasing indices.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        applyStimulus(1, 32'h44, 0, 0, 0);
        req_valid = 0;
        res_valid = 0;
        flush     = 0;
        #2;
        RESET = 1'b0;
        #1;
        modelReset();
        checkResetState("midreset");
        @(negedge CLK);
        RESET = 1'b1;
      end
      pc = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) pc = $urandom;
      applyStimulus($urandom_range(0, 9) < 6, pc, $urandom_range(0, 9) < 4,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0);
    end
    checkStats("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
